// File: rtl/branch_pkg.sv
// Shared constants for the branch resolve controller: branch funct3 codes and FSM encoding.
package branch_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_e;

  // funct3 010/011 are reserved in the branch opcode space.
  function automatic logic is_illegal_f3(input logic [2:0] f3);
    return f3[2:1] == 2'b01;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Request/compare/response bundle of the branch resolve controller.
// Stat counter signals exist only when BRANCH_STATS_EN is defined.
interface branch_resolve_ctrl_if #(
  parameter int unsigned XLEN = 32
`ifdef BRANCH_STATS_EN
  ,
  parameter int unsigned STAT_W = 32
`endif
);

  logic            req_valid;
  logic            req_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;

  logic [XLEN-1:0] cmp_rs1;
  logic [XLEN-1:0] cmp_rs2;
  logic            BrUn;
  logic            BrLT;
  logic            BrEq;

  logic            resp_valid;
  logic            resp_ready;
  logic            resp_taken;
  logic [XLEN-1:0] resp_target;
  logic            PCSel;
  logic            resp_illegal;
  logic            resp_misalign;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_taken;
`endif

  modport slave (
    input  req_valid, funct3, pc, imm, rs1_data, rs2_data, flush,
    input  BrLT, BrEq, resp_ready,
    output req_ready, cmp_rs1, cmp_rs2, BrUn,
    output resp_valid, resp_taken, resp_target, PCSel, resp_illegal, resp_misalign
`ifdef BRANCH_STATS_EN
    ,
    output stat_branches, stat_taken
`endif
  );

  modport master (
    output req_valid, funct3, pc, imm, rs1_data, rs2_data, flush,
    output BrLT, BrEq, resp_ready,
    input  req_ready, cmp_rs1, cmp_rs2, BrUn,
    input  resp_valid, resp_taken, resp_target, PCSel, resp_illegal, resp_misalign
`ifdef BRANCH_STATS_EN
    ,
    input  stat_branches, stat_taken
`endif
  );

endinterface

// File: rtl/branch_cond_decode.sv
// Combinational branch condition decode: funct3 plus comparator flags to taken/illegal/unsigned.
module branch_cond_decode
  import branch_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       br_lt_i,
  input  logic       br_eq_i,
  output logic       taken_o,
  output logic       illegal_o,
  output logic       unsigned_sel_o
);

  assign unsigned_sel_o = funct3_i[1];

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    unique case (funct3_i)
      BEQ:     taken_o = br_eq_i;
      BNE:     taken_o = ~br_eq_i;
      BLT:     taken_o = br_lt_i;
      BGE:     taken_o = ~br_lt_i;
      BLTU:    taken_o = br_lt_i;
      BGEU:    taken_o = ~br_lt_i;
      default: illegal_o = is_illegal_f3(funct3_i);
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Sequences the external Branch_comp for RV32I conditional branches: IDLE -> CMP -> RESP.
// Optional BRANCH_STATS_EN adds branch/taken handshake counters.
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
`ifdef BRANCH_STATS_EN
  ,
  parameter int unsigned STAT_W = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_resolve_ctrl_if.slave  bus
);

  state_e          state_q;
  logic            req_ready_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] cmp_rs1_q;
  logic [XLEN-1:0] cmp_rs2_q;
  logic            brun_q;
  logic            resp_valid_q;
  logic            resp_taken_q;
  logic [XLEN-1:0] resp_target_q;
  logic            pcsel_q;
  logic            resp_illegal_q;
  logic            resp_misalign_q;

  logic [2:0] dec_f3;
  logic       dec_taken;
  logic       dec_illegal;
  logic       dec_unsigned;

  // In IDLE the decoder looks at the incoming funct3 so BrUn is ready for the CMP cycle.
  assign dec_f3 = (state_q == IDLE) ? bus.funct3 : funct3_q;

  branch_cond_decode u_cond_decode (
    .funct3_i       (dec_f3),
    .br_lt_i        (bus.BrLT),
    .br_eq_i        (bus.BrEq),
    .taken_o        (dec_taken),
    .illegal_o      (dec_illegal),
    .unsigned_sel_o (dec_unsigned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      req_ready_q     <= 1'b1;
      funct3_q        <= '0;
      target_q        <= '0;
      cmp_rs1_q       <= '0;
      cmp_rs2_q       <= '0;
      brun_q          <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_taken_q    <= 1'b0;
      resp_target_q   <= '0;
      pcsel_q         <= 1'b0;
      resp_illegal_q  <= 1'b0;
      resp_misalign_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // flush has no meaning here; a request is accepted regardless.
          if (bus.req_valid) begin
            funct3_q    <= bus.funct3;
            target_q    <= bus.pc + bus.imm;
            cmp_rs1_q   <= bus.rs1_data;
            cmp_rs2_q   <= bus.rs2_data;
            brun_q      <= dec_unsigned;
            req_ready_q <= 1'b0;
            state_q     <= CMP;
          end
        end
        CMP: begin
          if (bus.flush) begin
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            resp_valid_q    <= 1'b1;
            resp_taken_q    <= dec_taken;
            resp_target_q   <= target_q;
            pcsel_q         <= dec_taken;
            resp_illegal_q  <= dec_illegal;
            resp_misalign_q <= dec_taken & (target_q[1:0] != 2'b00);
            state_q         <= RESP;
          end
        end
        RESP: begin
          if (bus.flush || bus.resp_ready) begin
            resp_valid_q    <= 1'b0;
            resp_taken_q    <= 1'b0;
            resp_target_q   <= '0;
            pcsel_q         <= 1'b0;
            resp_illegal_q  <= 1'b0;
            resp_misalign_q <= 1'b0;
            req_ready_q     <= 1'b1;
            state_q         <= IDLE;
          end
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.cmp_rs1       = cmp_rs1_q;
  assign bus.cmp_rs2       = cmp_rs2_q;
  assign bus.BrUn          = brun_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_taken    = resp_taken_q;
  assign bus.resp_target   = resp_target_q;
  assign bus.PCSel         = pcsel_q;
  assign bus.resp_illegal  = resp_illegal_q;
  assign bus.resp_misalign = resp_misalign_q;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_branches_q;
  logic [STAT_W-1:0] stat_taken_q;
  logic              resp_fire;

  // A flush in the same cycle as resp_ready cancels the handshake.
  assign resp_fire = resp_valid_q & bus.resp_ready & ~bus.flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches_q <= '0;
      stat_taken_q    <= '0;
    end else if (resp_fire) begin
      stat_branches_q <= stat_branches_q + STAT_W'(1);
      if (resp_taken_q) begin
        stat_taken_q <= stat_taken_q + STAT_W'(1);
      end
    end
  end

  assign bus.stat_branches = stat_branches_q;
  assign bus.stat_taken    = stat_taken_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed vectors, an architectural model and
// a per-cycle compare process. Stat checks are active when BRANCH_STATS_EN is defined.
module tb_branch_resolve_ctrl;
  import branch_pkg::*;

  localparam int unsigned XLEN = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  branch_resolve_ctrl_if #(.XLEN(XLEN)) bus ();

  branch_resolve_ctrl #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Stand-in for the external Branch_comp.
  assign bus.BrEq = (bus.cmp_rs1 == bus.cmp_rs2);
  assign bus.BrLT = bus.BrUn ? (bus.cmp_rs1 < bus.cmp_rs2)
                             : ($signed(bus.cmp_rs1) < $signed(bus.cmp_rs2));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- architectural model ----------------
  typedef struct packed {
    logic        taken;
    logic        illegal;
    logic        misalign;
    logic [31:0] target;
  } pred_t;

  function automatic pred_t predict(input logic [2:0] f3, input logic [31:0] pc,
                                    input logic [31:0] imm, input logic [31:0] a,
                                    input logic [31:0] b);
    pred_t p;
    p.target  = pc + imm;
    p.illegal = 1'b0;
    case (f3)
      3'b000:  p.taken = (a == b);
      3'b001:  p.taken = (a != b);
      3'b100:  p.taken = ($signed(a) < $signed(b));
      3'b101:  p.taken = ($signed(a) >= $signed(b));
      3'b110:  p.taken = (a < b);
      3'b111:  p.taken = (a >= b);
      default: begin
        p.taken   = 1'b0;
        p.illegal = 1'b1;
      end
    endcase
    p.misalign = p.taken && (p.target[1:0] != 2'b00);
    return p;
  endfunction

  // phase: 0 waiting for a request, 1 comparing, 2 response offered
  int          phase      = 0;
  pred_t       m_pred     = '0;
  logic [31:0] m_rs1      = '0;
  logic [31:0] m_rs2      = '0;
  logic        m_brun     = 1'b0;
  int          m_branches = 0;
  int          m_taken    = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      phase      = 0;
      m_pred     = '0;
      m_rs1      = '0;
      m_rs2      = '0;
      m_brun     = 1'b0;
      m_branches = 0;
      m_taken    = 0;
    end else if (phase == 0) begin
      if (bus.req_valid) begin
        m_pred = predict(bus.funct3, bus.pc, bus.imm, bus.rs1_data, bus.rs2_data);
        m_rs1  = bus.rs1_data;
        m_rs2  = bus.rs2_data;
        m_brun = bus.funct3[1];
        phase  = 1;
      end
    end else if (phase == 1) begin
      phase = bus.flush ? 0 : 2;
    end else begin
      if (bus.flush) phase = 0;
      else if (bus.resp_ready) begin
        m_branches++;
        if (m_pred.taken) m_taken++;
        phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk1("req_ready", bus.req_ready, phase == 0);
    chk1("resp_valid", bus.resp_valid, phase == 2);
    chk1("PCSel", bus.PCSel, (phase == 2) && m_pred.taken);
    chk32("cmp_rs1", bus.cmp_rs1, m_rs1);
    chk32("cmp_rs2", bus.cmp_rs2, m_rs2);
    chk1("BrUn", bus.BrUn, m_brun);
    if (phase == 2) begin
      chk1("resp_taken", bus.resp_taken, m_pred.taken);
      chk32("resp_target", bus.resp_target, m_pred.target);
      chk1("resp_illegal", bus.resp_illegal, m_pred.illegal);
      chk1("resp_misalign", bus.resp_misalign, m_pred.misalign);
    end
`ifdef BRANCH_STATS_EN
    chk32("stat_branches", bus.stat_branches, 32'(m_branches));
    chk32("stat_taken", bus.stat_taken, 32'(m_taken));
`endif
  end

  // ---------------- stimulus helpers (called at #1 after an edge) ----------------
  task automatic issue(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = 1'b1;
    bus.funct3    = f3;
    bus.pc        = pc;
    bus.imm       = imm;
    bus.rs1_data  = a;
    bus.rs2_data  = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int max_cycles);
    int k = 0;
    while (!bus.resp_valid && k < max_cycles) begin
      @(posedge clk); #1;
      k++;
    end
    if (!bus.resp_valid) chk1("resp_timeout", bus.resp_valid, 1'b1);
  endtask

  task automatic handshake();
    wait_resp(8);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic run_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                            input logic [31:0] a, input logic [31:0] b);
    issue(f3, pc, imm, a, b);
    handshake();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.funct3     = '0;
    bus.pc         = '0;
    bus.imm        = '0;
    bus.rs1_data   = '0;
    bus.rs2_data   = '0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk1("rst_req_ready", bus.req_ready, 1'b1);
    chk1("rst_resp_valid", bus.resp_valid, 1'b0);
    chk32("rst_cmp_rs1", bus.cmp_rs1, 32'h0);
    chk1("rst_BrUn", bus.BrUn, 1'b0);
    chk1("rst_PCSel", bus.PCSel, 1'b0);

    // BEQ: request driven after edge N, resp_valid after edge N+2.
    issue(BEQ, 32'h100, 32'h20, 32'h5, 32'h5);
    chk1("beq_lat_n1", bus.resp_valid, 1'b0);
    @(posedge clk); #1;
    chk1("beq_lat_n2", bus.resp_valid, 1'b1);
    chk1("beq_taken", bus.resp_taken, 1'b1);
    chk32("beq_target", bus.resp_target, 32'h120);
    chk1("beq_pcsel", bus.PCSel, 1'b1);
    handshake();

    // Signed vs unsigned compare on the same operands.
    issue(BLT, 32'h200, 32'h8, 32'hFFFF_FFFF, 32'h1);
    chk1("blt_brun", bus.BrUn, 1'b0);
    @(posedge clk); #1;
    chk1("blt_taken", bus.resp_taken, 1'b1);
    handshake();
    issue(BLTU, 32'h200, 32'h8, 32'hFFFF_FFFF, 32'h1);
    chk1("bltu_brun", bus.BrUn, 1'b1);
    @(posedge clk); #1;
    chk1("bltu_taken", bus.resp_taken, 1'b0);
    handshake();

    // Target wrap and misalignment.
    issue(BGE, 32'hFFFF_FFF0, 32'h20, 32'h7, 32'h7);
    @(posedge clk); #1;
    chk32("bge_wrap_target", bus.resp_target, 32'h0000_0010);
    chk1("bge_wrap_taken", bus.resp_taken, 1'b1);
    chk1("bge_wrap_misalign", bus.resp_misalign, 1'b0);
    handshake();
    issue(BGE, 32'hFFFF_FFF0, 32'h22, 32'h7, 32'h7);
    @(posedge clk); #1;
    chk32("bge_mis_target", bus.resp_target, 32'h0000_0012);
    chk1("bge_mis_misalign", bus.resp_misalign, 1'b1);
    handshake();

    // Illegal funct3 with back-pressure.
    issue(3'b010, 32'h40, 32'h8, 32'h1, 32'h2);
    @(posedge clk); #1;
    chk1("ill_illegal", bus.resp_illegal, 1'b1);
    chk1("ill_taken", bus.resp_taken, 1'b0);
    chk1("ill_pcsel", bus.PCSel, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk1("ill_hold_valid", bus.resp_valid, 1'b1);
      chk1("ill_hold_illegal", bus.resp_illegal, 1'b1);
      chk32("ill_hold_target", bus.resp_target, 32'h48);
    end
    handshake();

    // Assorted patterns checked by the model only.
    run_branch(BNE,    32'h1000, 32'hFFFF_FFFC, 32'h3, 32'h3);
    run_branch(BNE,    32'h1000, 32'hFFFF_FFFC, 32'h3, 32'h4);
    run_branch(BGEU,   32'h2000, 32'h10, 32'h1, 32'hFFFF_FFFF);
    run_branch(BGEU,   32'h2000, 32'h12, 32'hFFFF_FFFF, 32'h1);
    run_branch(BGE,    32'h3000, 32'h4, 32'h8000_0000, 32'h0);
    run_branch(BLT,    32'h3000, 32'h6, 32'h8000_0000, 32'h7FFF_FFFF);
    run_branch(3'b011, 32'h4000, 32'h4, 32'h0, 32'h0);
    run_branch(BEQ,    32'h4000, 32'h4, 32'h1, 32'h0);

    // flush in CMP.
    issue(BEQ, 32'h500, 32'h4, 32'h9, 32'h9);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk1("flush_cmp_ready", bus.req_ready, 1'b1);
    chk1("flush_cmp_valid", bus.resp_valid, 1'b0);
    @(posedge clk); #1;
    chk1("flush_cmp_novalid", bus.resp_valid, 1'b0);

    // flush in RESP together with resp_ready.
    issue(BEQ, 32'h600, 32'h4, 32'h9, 32'h9);
    @(posedge clk); #1;
    bus.flush      = 1'b1;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b0;
    chk1("flush_resp_ready", bus.req_ready, 1'b1);
    chk1("flush_resp_valid", bus.resp_valid, 1'b0);

    // flush in IDLE does not block acceptance.
    bus.flush = 1'b1;
    issue(BNE, 32'h700, 32'h8, 32'h1, 32'h2);
    bus.flush = 1'b0;
    @(posedge clk); #1;
    chk1("flush_idle_valid", bus.resp_valid, 1'b1);
    chk1("flush_idle_taken", bus.resp_taken, 1'b1);
    handshake();

    // Asynchronous reset in CMP.
    issue(BEQ, 32'h800, 32'h8, 32'h5, 32'h5);
    #2 reset = 1'b1;
    #1;
    chk1("arst_req_ready", bus.req_ready, 1'b1);
    chk1("arst_resp_valid", bus.resp_valid, 1'b0);
    chk32("arst_cmp_rs1", bus.cmp_rs1, 32'h0);
    chk1("arst_BrUn", bus.BrUn, 1'b0);
    chk1("arst_PCSel", bus.PCSel, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk1("arst_no_resp", bus.resp_valid, 1'b0);
    end

`ifdef BRANCH_STATS_EN
    // Counters start from the reset just applied.
    run_branch(BEQ, 32'h900, 32'h4, 32'h5, 32'h5);
    run_branch(BNE, 32'h900, 32'h4, 32'h5, 32'h5);
    run_branch(BLT, 32'h900, 32'h4, 32'hFFFF_FFFF, 32'h1);
    chk32("stats_branches", bus.stat_branches, 32'd3);
    chk32("stats_taken", bus.stat_taken, 32'd2);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
